// File: rtl/fuzz_req_sequencer_pkg.sv
// fuzz_pkg: shared types and helpers for the fuzz request sequencer.
//   state_t      - sequencer FSM state encoding
//   LFSR_TAPS    - Galois feedback mask (x^32 + x^22 + x^2 + x + 1)
//   LFSR_RESET   - LFSR value after reset, also substituted for a zero seed
//   lfsr_next()  - one Galois step, right-shifting form
package fuzz_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GEN     = 3'd1,
        S_WR_REQ  = 3'd2,
        S_WR_WAIT = 3'd3,
        S_RD_REQ  = 3'd4,
        S_RD_WAIT = 3'd5,
        S_CHECK   = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
    localparam logic [31:0] LFSR_RESET = 32'h0000_0001;

    function automatic logic [31:0] lfsr_next(input logic [31:0] value);
        return (value >> 1) ^ (value[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/fuzz_req_sequencer_if.sv
// fuzz_req_sequencer_if: burst request channel between the sequencer and
// the external master bridge.
//   ext_master_req         - single-cycle request pulse
//   ext_master_we          - 1 = write burst, 0 = read burst
//   ext_master_addr_read   - read burst start address
//   ext_master_addr_write  - write burst start address
//   ext_master_wdata       - write payload
//   ext_master_rdata       - read payload returned by the bridge
//   ext_master_read_done   - read complete (level, cleared on next req)
//   ext_master_write_done  - write complete (level, cleared on next req)
// Modports: master = sequencer side, slave = bridge side.
interface fuzz_req_sequencer_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int EXT_RW_WIDTH = 256
);
    logic                    ext_master_req;
    logic                    ext_master_we;
    logic [ADDR_WIDTH-1:0]   ext_master_addr_read;
    logic [ADDR_WIDTH-1:0]   ext_master_addr_write;
    logic [EXT_RW_WIDTH-1:0] ext_master_wdata;
    logic [EXT_RW_WIDTH-1:0] ext_master_rdata;
    logic                    ext_master_read_done;
    logic                    ext_master_write_done;

    modport master (
        output ext_master_req,
        output ext_master_we,
        output ext_master_addr_read,
        output ext_master_addr_write,
        output ext_master_wdata,
        input  ext_master_rdata,
        input  ext_master_read_done,
        input  ext_master_write_done
    );

    modport slave (
        input  ext_master_req,
        input  ext_master_we,
        input  ext_master_addr_read,
        input  ext_master_addr_write,
        input  ext_master_wdata,
        output ext_master_rdata,
        output ext_master_read_done,
        output ext_master_write_done
    );
endinterface

// File: rtl/fuzz_req_sequencer_lfsr.sv
// fuzz_lfsr32: 32-bit Galois LFSR used as the address/data source.
//   clk, rst  - clock, asynchronous active-high reset (value -> 1)
//   load      - load seed (a zero seed is replaced by 1, the all-zero
//               state would lock the register)
//   seed      - value to load
//   advance   - step once this cycle (ignored while load is high)
//   value     - current LFSR state
module fuzz_lfsr32
    import fuzz_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        advance,
    output logic [31:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= LFSR_RESET;
        end else if (load) begin
            value <= (seed == 32'h0) ? LFSR_RESET : seed;
        end else if (advance) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/fuzz_req_sequencer.sv
// fuzz_req_sequencer: generates pseudo-random write bursts, reads each one
// back through the external bridge and checks/hashes the returned data.
//   clk, rst        - clock, asynchronous active-high reset
//   start, stop     - begin a run / end it at the next pair boundary
//   seed            - LFSR seed loaded on start
//   base_addr       - fixed address bits
//   addr_mask       - address bits taken from the LFSR
//   num_txn         - write/readback pairs per run
//   bus             - burst channel to the bridge (master side)
//   busy, done      - run active / run finished (held until next start)
//   txn_count       - completed pairs
//   mismatch_count  - readbacks differing from the written payload
//   timeout_err     - a wait state ran out (sticky for the run)
//   signature       - rolling hash of all readback data
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | after reset, waiting for start
//   GEN     | cycle 0 latches address, cycles 1..BURST_LEN fill wdata
//   WR_REQ  | one-cycle write request
//   WR_WAIT | waiting for write_done, bounded by TIMEOUT_CYCLES
//   RD_REQ  | one-cycle read request
//   RD_WAIT | waiting for read_done, captures rdata
//   CHECK   | compare, count, update signature
//   DONE    | run finished, results held until next start
module fuzz_req_sequencer
    import fuzz_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int EXT_RW_WIDTH   = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [31:0]           seed,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] addr_mask,
    input  logic [15:0]           num_txn,
    fuzz_req_sequencer_if.master  bus,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           txn_count,
    output logic [15:0]           mismatch_count,
    output logic                  timeout_err,
    output logic [31:0]           signature
);

    localparam int BURST_LEN = EXT_RW_WIDTH / DATA_WIDTH;
    localparam int GEN_W     = $clog2(BURST_LEN + 1);
    localparam int WAIT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT_CYCLES - 1);

    state_t state;
    state_t state_next;

    logic [31:0]             lfsr_value;
    logic [GEN_W-1:0]        gen_cnt;
    logic [WAIT_W-1:0]       wait_cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [EXT_RW_WIDTH-1:0] wdata_q;
    logic [EXT_RW_WIDTH-1:0] rdata_q;
    logic                    stop_seen;
    logic                    req_now;
    logic                    we_now;
    logic [ADDR_WIDTH-1:0]   gen_addr;
    logic [31:0]             rd_fold;
    logic [15:0]             txn_next;
    logic                    start_ok;
    logic                    gen_last;
    logic                    wait_tc;
    logic                    run_last;

    assign start_ok = start && (state == S_IDLE || state == S_DONE);
    assign gen_last = (gen_cnt == GEN_W'(BURST_LEN));
    assign wait_tc  = (wait_cnt == '0);
    assign txn_next = txn_count + 16'd1;
    // stop sampled in the CHECK cycle itself also ends the run here
    assign run_last = (txn_next == num_txn) || stop_seen || stop;

    // Low five bits cleared so every burst starts 32-byte aligned.
    assign gen_addr = ((base_addr & ~addr_mask) | (ADDR_WIDTH'(lfsr_value) & addr_mask))
                      & ~ADDR_WIDTH'(32'h1F);

    always_comb begin
        rd_fold = '0;
        for (int i = 0; i < BURST_LEN; i++) begin
            rd_fold = rd_fold ^ 32'(rdata_q[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    fuzz_lfsr32 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (start_ok),
        .seed    (seed),
        .advance (state == S_GEN),
        .value   (lfsr_value)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = (num_txn == 16'd0) ? S_DONE : S_GEN;
                end
            end
            S_GEN: begin
                if (gen_last) begin
                    state_next = S_WR_REQ;
                end
            end
            S_WR_REQ: state_next = S_WR_WAIT;
            S_WR_WAIT: begin
                if (bus.ext_master_write_done) begin
                    state_next = S_RD_REQ;
                end else if (wait_tc) begin
                    state_next = S_DONE;
                end
            end
            S_RD_REQ: state_next = S_RD_WAIT;
            S_RD_WAIT: begin
                if (bus.ext_master_read_done) begin
                    state_next = S_CHECK;
                end else if (wait_tc) begin
                    state_next = S_DONE;
                end
            end
            S_CHECK: state_next = run_last ? S_DONE : S_GEN;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_now = 1'b0;
        we_now  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            S_GEN, S_RD_WAIT, S_CHECK: busy = 1'b1;
            S_WR_REQ: begin
                busy    = 1'b1;
                req_now = 1'b1;
                we_now  = 1'b1;
            end
            S_WR_WAIT: begin
                busy   = 1'b1;
                we_now = 1'b1;
            end
            S_RD_REQ: begin
                busy    = 1'b1;
                req_now = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gen_cnt        <= '0;
            wait_cnt       <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            stop_seen      <= 1'b0;
            txn_count      <= '0;
            mismatch_count <= '0;
            timeout_err    <= 1'b0;
            signature      <= '0;
        end else begin
            if (start_ok) begin
                gen_cnt        <= '0;
                stop_seen      <= 1'b0;
                txn_count      <= '0;
                mismatch_count <= '0;
                timeout_err    <= 1'b0;
                signature      <= '0;
            end
            if (busy && stop) begin
                stop_seen <= 1'b1;
            end
            case (state)
                S_GEN: begin
                    gen_cnt <= gen_last ? '0 : gen_cnt + GEN_W'(1);
                    if (gen_cnt == '0) begin
                        addr_q <= gen_addr;
                    end
                    for (int i = 0; i < BURST_LEN; i++) begin
                        if (gen_cnt == GEN_W'(i + 1)) begin
                            wdata_q[i*DATA_WIDTH +: DATA_WIDTH] <= DATA_WIDTH'(lfsr_value);
                        end
                    end
                end
                S_WR_REQ, S_RD_REQ: wait_cnt <= WAIT_LOAD;
                S_WR_WAIT: begin
                    if (!bus.ext_master_write_done) begin
                        if (wait_tc) begin
                            timeout_err <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt - WAIT_W'(1);
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (bus.ext_master_read_done) begin
                        rdata_q <= bus.ext_master_rdata;
                    end else if (wait_tc) begin
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                S_CHECK: begin
                    txn_count <= txn_next;
                    if (rdata_q != wdata_q && mismatch_count != 16'hFFFF) begin
                        mismatch_count <= mismatch_count + 16'd1;
                    end
                    signature <= {signature[30:0], signature[31]} ^ rd_fold;
                end
                default: ;
            endcase
        end
    end

    assign bus.ext_master_req        = req_now;
    assign bus.ext_master_we         = we_now;
    assign bus.ext_master_addr_read  = addr_q;
    assign bus.ext_master_addr_write = addr_q;
    assign bus.ext_master_wdata      = wdata_q;

endmodule

// File: tb/tb_fuzz_req_sequencer.sv
// tb_fuzz_req_sequencer: scoreboard bench for fuzz_req_sequencer. A
// reference model expands each run into its expected request stream and
// end-of-run results; a monitor pops and compares them as the DUT issues
// requests and finishes; an echo-memory bridge model answers requests.
module tb_fuzz_req_sequencer;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int EW = 256;
    localparam int BL = EW / DW;
    localparam int TO = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic [31:0]   seed;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] addr_mask;
    logic [15:0]   num_txn;
    logic          busy;
    logic          done;
    logic [15:0]   txn_count;
    logic [15:0]   mismatch_count;
    logic          timeout_err;
    logic [31:0]   signature;

    fuzz_req_sequencer_if #(.ADDR_WIDTH(AW), .EXT_RW_WIDTH(EW)) bus_if ();

    fuzz_req_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .EXT_RW_WIDTH(EW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stop           (stop),
        .seed           (seed),
        .base_addr      (base_addr),
        .addr_mask      (addr_mask),
        .num_txn        (num_txn),
        .bus            (bus_if),
        .busy           (busy),
        .done           (done),
        .txn_count      (txn_count),
        .mismatch_count (mismatch_count),
        .timeout_err    (timeout_err),
        .signature      (signature)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit            we;
        logic [31:0]   addr;
        logic [EW-1:0] wdata;
    } req_t;

    typedef struct {
        logic [15:0] txn;
        logic [15:0] mism;
        bit          tmo;
        logic [31:0] sig;
    } end_t;

    req_t exp_req_q[$];
    end_t exp_end_q[$];

    // Galois LFSR step: shift right, fold the polynomial back in when a 1 drops out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        logic [31:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    // Expected requests and results of a whole run against the echo bridge.
    task automatic model_run(input logic [31:0] s, input logic [31:0] b, input logic [31:0] m,
                             input int pairs, input int corrupt, input bit wr_timeout);
        logic [31:0]   l;
        logic [31:0]   sig;
        logic [31:0]   fold;
        logic [EW-1:0] wd;
        logic [EW-1:0] rd;
        int            mism;
        int            total;
        req_t          r;
        end_t          e;
        l     = (s == 32'h0) ? 32'h1 : s;
        sig   = 32'h0;
        mism  = 0;
        total = wr_timeout ? 1 : pairs;
        for (int p = 1; p <= total; p++) begin
            r.addr = ((b & ~m) | (l & m)) & 32'hFFFF_FFE0;
            l = lfsr_step(l);
            for (int w = 0; w < BL; w++) begin
                wd[w*32 +: 32] = l;
                l = lfsr_step(l);
            end
            r.wdata = wd;
            r.we    = 1'b1;
            exp_req_q.push_back(r);
            if (!wr_timeout) begin
                r.we = 1'b0;
                exp_req_q.push_back(r);
                rd = wd;
                if (p == corrupt) rd[0] = ~rd[0];
                if (rd != wd) mism++;
                fold = 32'h0;
                for (int w = 0; w < BL; w++) fold = fold ^ rd[w*32 +: 32];
                sig = {sig[30:0], sig[31]} ^ fold;
            end
        end
        e.txn  = wr_timeout ? 16'd0 : 16'(pairs);
        e.mism = 16'(mism);
        e.tmo  = wr_timeout;
        e.sig  = sig;
        exp_end_q.push_back(e);
    endtask

    // Echo-memory bridge, acting on the falling edge.
    bit            hold_write = 1'b0;
    int            corrupt_pair = 0;
    logic [EW-1:0] mem [bit [31:0]];
    int            wr_lat;
    int            rd_lat;
    int            rd_idx;
    logic [31:0]   rd_addr;

    initial begin
        bus_if.ext_master_rdata      = '0;
        bus_if.ext_master_read_done  = 1'b0;
        bus_if.ext_master_write_done = 1'b0;
        wr_lat  = 0;
        rd_lat  = 0;
        rd_idx  = 0;
        rd_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus_if.ext_master_read_done  = 1'b0;
                bus_if.ext_master_write_done = 1'b0;
                wr_lat = 0;
                rd_lat = 0;
                rd_idx = 0;
            end else begin
                if (!busy) rd_idx = 0;
                if (bus_if.ext_master_req) begin
                    bus_if.ext_master_read_done  = 1'b0;
                    bus_if.ext_master_write_done = 1'b0;
                    if (bus_if.ext_master_we) begin
                        mem[bus_if.ext_master_addr_write] = bus_if.ext_master_wdata;
                        wr_lat = $urandom_range(1, 5);
                    end else begin
                        rd_addr = bus_if.ext_master_addr_read;
                        rd_lat  = $urandom_range(1, 5);
                        rd_idx++;
                    end
                end else begin
                    if (wr_lat > 0) begin
                        wr_lat--;
                        if (wr_lat == 0 && !hold_write) bus_if.ext_master_write_done = 1'b1;
                    end
                    if (rd_lat > 0) begin
                        rd_lat--;
                        if (rd_lat == 0) begin
                            bus_if.ext_master_rdata = mem.exists(rd_addr) ? mem[rd_addr] : '0;
                            if (rd_idx == corrupt_pair)
                                bus_if.ext_master_rdata[0] = ~bus_if.ext_master_rdata[0];
                            bus_if.ext_master_read_done = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Monitor / scoreboard.
    req_t          mon_r;
    end_t          mon_e;
    bit            prev_req = 1'b0;
    bit            prev_done = 1'b0;
    bit            in_write = 1'b0;
    logic [31:0]   held_addr;
    logic [EW-1:0] held_wdata;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req  = 1'b0;
                prev_done = 1'b0;
                in_write  = 1'b0;
            end else begin
                if (bus_if.ext_master_req) begin
                    checks++;
                    if (prev_req) begin
                        errors++;
                        $display("FAIL req_pulse: req high on consecutive cycles, expected 1 cycle");
                    end
                    checks++;
                    if (exp_req_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_req: we=%0b addr=%h, expected no request",
                                 bus_if.ext_master_we, bus_if.ext_master_addr_write);
                    end else begin
                        mon_r = exp_req_q.pop_front();
                        if (bus_if.ext_master_we !== mon_r.we ||
                            bus_if.ext_master_addr_write !== mon_r.addr ||
                            bus_if.ext_master_addr_read !== mon_r.addr ||
                            bus_if.ext_master_wdata !== mon_r.wdata) begin
                            errors++;
                            $display("FAIL req: got we=%0b aw=%h ar=%h wd=%h exp we=%0b a=%h wd=%h",
                                     bus_if.ext_master_we, bus_if.ext_master_addr_write,
                                     bus_if.ext_master_addr_read, bus_if.ext_master_wdata,
                                     mon_r.we, mon_r.addr, mon_r.wdata);
                        end
                    end
                    in_write   = bus_if.ext_master_we;
                    held_addr  = bus_if.ext_master_addr_write;
                    held_wdata = bus_if.ext_master_wdata;
                end else if (!busy) begin
                    in_write = 1'b0;
                end else if (in_write) begin
                    checks++;
                    if (bus_if.ext_master_we !== 1'b1 ||
                        bus_if.ext_master_addr_write !== held_addr ||
                        bus_if.ext_master_addr_read !== held_addr ||
                        bus_if.ext_master_wdata !== held_wdata) begin
                        errors++;
                        $display("FAIL write_hold: we=%0b addr=%h, expected we=1 addr=%h and stable wdata",
                                 bus_if.ext_master_we, bus_if.ext_master_addr_write, held_addr);
                    end
                end
                if (done && !prev_done) begin
                    checks++;
                    if (exp_end_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done: done rose with no run expected");
                    end else begin
                        mon_e = exp_end_q.pop_front();
                        if (txn_count !== mon_e.txn || mismatch_count !== mon_e.mism ||
                            timeout_err !== mon_e.tmo || signature !== mon_e.sig || busy !== 1'b0) begin
                            errors++;
                            $display("FAIL run_end: got txn=%0d mism=%0d tmo=%0b sig=%h busy=%0b exp txn=%0d mism=%0d tmo=%0b sig=%h busy=0",
                                     txn_count, mismatch_count, timeout_err, signature, busy,
                                     mon_e.txn, mon_e.mism, mon_e.tmo, mon_e.sig);
                        end
                    end
                    checks++;
                    if (exp_req_q.size() != 0) begin
                        errors++;
                        $display("FAIL missing_req: %0d requests outstanding at done, expected 0",
                                 exp_req_q.size());
                    end
                end
                prev_req  = bus_if.ext_master_req;
                prev_done = done;
            end
        end
    end

    task automatic check_zero(input string tag);
        checks++;
        if (bus_if.ext_master_req !== 1'b0 || bus_if.ext_master_we !== 1'b0 ||
            bus_if.ext_master_addr_read !== '0 || bus_if.ext_master_addr_write !== '0 ||
            bus_if.ext_master_wdata !== '0 || busy !== 1'b0 || done !== 1'b0 ||
            txn_count !== '0 || mismatch_count !== '0 || timeout_err !== 1'b0 ||
            signature !== '0) begin
            errors++;
            $display("FAIL %s: req=%0b we=%0b addr=%h busy=%0b done=%0b txn=%0d mism=%0d tmo=%0b sig=%h, expected all 0",
                     tag, bus_if.ext_master_req, bus_if.ext_master_we, bus_if.ext_master_addr_write,
                     busy, done, txn_count, mismatch_count, timeout_err, signature);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        #1;
        check_zero("reset_state");
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start(input logic [31:0] s, input logic [31:0] b, input logic [31:0] m,
                               input logic [15:0] n);
        @(negedge clk);
        seed      = s;
        base_addr = b;
        addr_mask = m;
        num_txn   = n;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: done not seen within %0d cycles, expected done=1", tag, limit);
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [31:0] s, input logic [31:0] b, input logic [31:0] m,
                       input int n, input int corrupt, input string tag);
        corrupt_pair = corrupt;
        model_run(s, b, m, n, corrupt, 1'b0);
        pulse_start(s, b, m, 16'(n));
        wait_done(tag, 3000);
    endtask

    logic [31:0]   sig_a;
    logic [EW-1:0] wd_a;

    initial begin
        int n;
        int cnt;
        logic [31:0] rs, rb, rm;
        int rn;
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        seed = '0; base_addr = '0; addr_mask = '0; num_txn = '0;
        do_reset();

        run(32'h1, 32'h1000_0000, 32'h0000_0FFF, 4, 0, "basic_4");
        run($urandom, 32'h1000_0000, 32'h0000_0FFF, 3, 2, "corrupt_pair2");

        run(32'h0, 32'h2000_0000, 32'h00FF_FFFF, 3, 0, "seed0");
        sig_a = signature;
        wd_a  = bus_if.ext_master_wdata;
        run(32'h1, 32'h2000_0000, 32'h00FF_FFFF, 3, 0, "seed1");
        checks++;
        if (signature !== sig_a || bus_if.ext_master_wdata !== wd_a) begin
            errors++;
            $display("FAIL seed0_vs_seed1: sig %h vs %h, wdata equal=%0b, expected identical",
                     signature, sig_a, bus_if.ext_master_wdata === wd_a);
        end

        // stop pulsed while pair 5 is in flight
        corrupt_pair = 0;
        rs = $urandom;
        model_run(rs, 32'h4000_0000, 32'h0000_FFFF, 5, 0, 1'b0);
        pulse_start(rs, 32'h4000_0000, 32'h0000_FFFF, 16'd100);
        cnt = 0; n = 0;
        while (cnt < 5 && n < 1000) begin
            @(negedge clk);
            n++;
            if (bus_if.ext_master_req && bus_if.ext_master_we) cnt++;
        end
        checks++;
        if (cnt != 5) begin
            errors++;
            $display("FAIL stop_wait: saw %0d write requests, expected 5", cnt);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done("stop_run", 3000);

        // write never completes
        hold_write = 1'b1;
        rs = $urandom;
        model_run(rs, 32'h1000_0000, 32'h0000_0FFF, 3, 0, 1'b1);
        pulse_start(rs, 32'h1000_0000, 32'h0000_0FFF, 16'd3);
        n = 0;
        while (!bus_if.ext_master_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!done && n < TO + 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != TO + 1) begin
            errors++;
            $display("FAIL timeout_latency: done %0d cycles after req, expected %0d", n, TO + 1);
        end
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus_if.ext_master_req) cnt++;
        end
        checks++;
        if (cnt != 0 || done !== 1'b1) begin
            errors++;
            $display("FAIL after_timeout: %0d requests, done=%0b, expected 0 requests and done=1", cnt, done);
        end
        hold_write = 1'b0;
        do_reset();

        // reset while waiting for a read
        rs = $urandom;
        model_run(rs, 32'h3000_0000, 32'h000F_FFFF, 2, 0, 1'b0);
        pulse_start(rs, 32'h3000_0000, 32'h000F_FFFF, 16'd2);
        n = 0;
        while (!(bus_if.ext_master_req && !bus_if.ext_master_we) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("reset_in_rd_wait");
        exp_req_q.delete();
        exp_end_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run(rs, 32'h3000_0000, 32'h000F_FFFF, 2, 0, "after_reset");

        // num_txn = 0 from IDLE
        do_reset();
        model_run(32'h5, 32'h0, 32'h0, 0, 0, 1'b0);
        pulse_start(32'h5, 32'h0, 32'h0, 16'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || bus_if.ext_master_req !== 1'b0) begin
            errors++;
            $display("FAIL zero_txn: done=%0b busy=%0b req=%0b, expected done=1 busy=0 req=0",
                     done, busy, bus_if.ext_master_req);
        end
        @(negedge clk);

        for (int r = 0; r < 4; r++) begin
            rs = $urandom;
            rb = $urandom;
            rm = $urandom;
            rn = $urandom_range(1, 5);
            run(rs, rb, rm, rn, $urandom_range(0, rn), "random_run");
        end

        checks++;
        if (exp_req_q.size() != 0 || exp_end_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d requests, %0d results not observed, expected 0",
                     exp_req_q.size(), exp_end_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fuzz_req_sequencer.md
FUZZ_REQ_SEQUENCER -- requirements
Module: fuzz_req_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bus word width used for LFSR fill.
REQ-003 SHALL have parameter EXT_RW_WIDTH, default 256, burst payload width; BURST_LEN = EXT_RW_WIDTH/DATA_WIDTH.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, max cycles in a wait state.
REQ-005 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  in  1  begin run; sampled only in IDLE or DONE.
REQ-008 SHALL have port stop  in  1  end run at next transaction boundary.
REQ-009 SHALL have port seed  in  32  LFSR seed, loaded on start.
REQ-010 SHALL have port base_addr  in  ADDR_WIDTH  fixed address bits.
REQ-011 SHALL have port addr_mask  in  ADDR_WIDTH  bits taken from LFSR.
REQ-012 SHALL have port num_txn  in  16  write/readback pairs per run.
REQ-013 SHALL have port ext_master_req  out  1  single-cycle request pulse to bridge.
REQ-014 SHALL have port ext_master_we  out  1  1 = write burst, 0 = read burst.
REQ-015 SHALL have port ext_master_addr_read  out  ADDR_WIDTH  read burst start address.
REQ-016 SHALL have port ext_master_addr_write  out  ADDR_WIDTH  write burst start address.
REQ-017 SHALL have port ext_master_wdata  out  EXT_RW_WIDTH  write payload.
REQ-018 SHALL have port ext_master_rdata  in  EXT_RW_WIDTH  read payload from bridge.
REQ-019 SHALL have port ext_master_read_done  in  1  bridge read complete (level, cleared by bridge on next req).
REQ-020 SHALL have port ext_master_write_done  in  1  bridge write complete (level, same rule).
REQ-021 SHALL have ports busy/done  out  1 each  run active / run finished (done held until next start).
REQ-022 SHALL have ports txn_count/mismatch_count  out  16 each  completed pairs / readback mismatches.
REQ-023 SHALL have ports timeout_err  out  1 (sticky per run) and signature  out  32  readback hash.

Function
REQ-024 FSM states SHALL be IDLE, GEN, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, DONE.
REQ-025 start in IDLE/DONE SHALL load LFSR (seed 0 replaced by 0x00000001), clear counters/signature/timeout_err/done, set busy, go GEN; num_txn=0 SHALL go directly to DONE.
REQ-026 LFSR SHALL be 32-bit Galois, taps 0x80200003, advancing one step per cycle in GEN only.
REQ-027 GEN SHALL last BURST_LEN+1 cycles: cycle 0 latches address = ((base_addr & ~addr_mask) | (lfsr & addr_mask)) with bits [4:0] forced 0; cycles 1..BURST_LEN fill wdata word i (bits i*32 +: 32) with current LFSR value.
REQ-028 Both address outputs SHALL carry the latched address and, with wdata, SHALL stay stable from WR_REQ through CHECK.
REQ-029 WR_REQ/RD_REQ SHALL each assert ext_master_req for exactly one cycle with we=1/0, then enter WR_WAIT/RD_WAIT; we SHALL hold its value through the wait.
REQ-030 WR_WAIT SHALL advance to RD_REQ on write_done=1; RD_WAIT SHALL capture rdata and advance to CHECK on read_done=1; done inputs SHALL be ignored in all other states.
REQ-031 A wait counter SHALL reset on entering each wait state; reaching TIMEOUT_CYCLES SHALL set timeout_err and go DONE (bridge is not aborted).
REQ-032 CHECK (1 cycle) SHALL increment txn_count (16-bit wrap), increment mismatch_count (saturating at 0xFFFF) if captured rdata != wdata, and update signature = rotl1(signature) ^ XOR of all BURST_LEN rdata words.
REQ-033 After CHECK: DONE if txn_count (updated value) == num_txn or stop was seen at any point since GEN; else GEN.
REQ-034 DONE SHALL clear busy, set done; outputs hold until next start; start while busy SHALL be ignored.

Reset
REQ-035 rst SHALL force IDLE and drive every output to 0 (req, we, addresses, wdata, busy, done, counts, timeout_err, signature) and LFSR to 0x00000001.
REQ-036 rst mid-run SHALL abandon the transaction without any further req pulse; sequencer and bridge are reset together.

Structure
REQ-037 Package fuzz_pkg SHALL hold the FSM state typedef, the LFSR tap constant and a next-LFSR function.
REQ-038 LFSR SHALL be a sub-module fuzz_lfsr32 (load, seed, advance, value).

Verification
REQ-039 seed=0x1, base=0x1000_0000, mask=0x0000_0FFF, num_txn=4, echo-memory bridge model -> 4 write/read pairs, addresses 32-byte aligned within 0x1000_0000..0x1000_0FE0, txn_count=4, mismatch_count=0, done=1.
REQ-040 Bridge model corrupts bit 0 of readback on pair 2 of num_txn=3 -> mismatch_count=1, txn_count=3.
REQ-041 Bridge model never asserts write_done -> timeout_err=1 and DONE after exactly 1024 wait cycles; no further req.
REQ-042 num_txn=100, stop pulsed during pair 5 -> run ends after pair 5 CHECK, txn_count=5.
REQ-043 seed=0 vs seed=1 runs -> identical wdata and signature; num_txn=0 -> done next cycle, no req.
REQ-044 rst asserted in RD_WAIT -> all outputs 0 next edge; subsequent start completes normally.
